freq_synth_bcd: RTL and testbench
=================================

// Module: freq_synth_bcd
// PURPOSE
//  Frequency synthesiser; the inverse of the gate-time frequency meter. Takes a 7-digit BCD
//  frequency in Hz (same digit order as the meter: p1 = MSD, p7 = LSD). On a load strobe it
//  converts to binary sequentially, then emits a 50%-average square wave at that frequency.
//  Uses a fractional accumulator. Feeds the test-signal output pin and can be looped back to the meter.
// PARAMETERS
//  CLK_HZ  50_000_000  system clock frequency in Hz
//  ACC_W   27          accumulator width; must hold 2*CLK_HZ-1
// PORTS
//  clk       in   1   system clock (CLK_HZ)
//  rst_n     in   1   asynchronous active-low reset
//  load      in   1   one-cycle request to apply p1..p7
//  p1..p7    in   4   BCD digits each; p1 = 10^6 ... p7 = 10^0
//  busy      out  1   conversion in progress; load is ignored while high
//  err       out  1   last load was rejected (non-BCD digit or out of range)
//  freq_bin  out  24  active frequency in Hz (binary)
//  fout      out  1   synthesised square wave
// BEHAVIOUR
//  Reset (async): state=IDLE; busy=0, err=0, freq_bin=0, fout=0, accumulator=0.
//  FSM states: IDLE -> CONV -> APPLY -> IDLE.
//  IDLE:
//   - load=1 with every digit <=9: latch the digits, bin=0, idx=0, busy<=1, go to CONV.
//   - load=1 with any digit >9: err<=1, stay in IDLE, freq_bin unchanged.
//  CONV: 7 edges, one per digit. Each edge: bin <= bin*10 + digit[idx] (p1 first), idx++.
//   bin is 24 bits wide; the maximum value 9_999_999 fits.
//  APPLY (1 edge):
//   - If 2*bin >= CLK_HZ: err<=1, freq_bin unchanged.
//   - Otherwise: freq_bin<=bin, err<=0, acc<=0.
//   - In both cases busy<=0 and the FSM returns to IDLE.
//  Latency: load sampled at edge k; busy is high after edges k..k+7 and low after edge k+8.
//   The new freq_bin is visible after edge k+8 and drives fout from edge k+9.
//  load asserted while busy=1: ignored. It is not queued and err is not changed.
//  Synthesis (every edge, independent of FSM):
//   - s = acc + 2*freq_bin.
//   - If s >= CLK_HZ: acc <= s - CLK_HZ and fout toggles. Otherwise acc <= s.
//   - Toggle rate is 2*freq_bin per second; the long-run frequency is exact.
//   - Individual periods may jitter by 1 clk.
//  freq_bin == 0: acc holds at 0 and fout holds its current level.
//  Frequency change at APPLY: acc cleared and fout is NOT forced. The waveform continues
//   from its current level, with no runt pulse shorter than 1 clk.
//  Upper bound: freq_bin <= CLK_HZ/2 - 1 (24_999_999 at the default, so all BCD inputs pass).
//  Reset mid-CONV: conversion aborted, all outputs return to their reset values.
// TESTING (bench sets CLK_HZ=1000 unless noted)
//  1. Reset, then load 0000001 -> busy high 8 cycles; freq_bin=1; fout toggles every 500
//     clks (period 1000).
//  2. Load 0000250 -> fout period exactly 4 clks (2 high/2 low).
//     Then load 0000300 -> exactly 300 rising edges in 1000 clks, each period 3 or 4 clks.
//  3. Load 0000600 (2*600 >= 1000) -> err=1 after edge k+8; freq_bin and fout frequency unchanged.
//     Then load 0000100 -> err=0.
//  4. Load with p4=4'hA -> err=1 on the next edge, busy never rises.
//     Then load 0000000 -> freq_bin=0, fout frozen at its level.
//  5. Second load pulse at cycle k+3 while busy -> ignored; result equals the first load;
//     busy low after k+8.
//  6. Default CLK_HZ: load 9999999 -> freq_bin=9_999_999; exactly 1_999_999_8 toggles
//     in 50_000_000 clks.
//     Also: rst_n low during CONV -> busy=0, freq_bin=0, fout=0 immediately.

Source files
------------

// File: rtl/freq_synth_bcd.sv
// freq_synth_bcd: BCD-programmed frequency synthesiser.
// A load strobe latches seven BCD digits (p1 = MSD). The digits are converted to
// binary one per clock, range-checked, and then applied to a fractional phase
// accumulator. The accumulator adds 2*freq_bin every clock and toggles fout each
// time it passes CLK_HZ. This gives 2*freq_bin toggles per second, which is a
// square wave at freq_bin Hz with an exact long-run rate.
`timescale 1ns/1ps
module freq_synth_bcd #(
    parameter int CLK_HZ = 50_000_000,
    parameter int ACC_W  = 27
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load,
    input  logic [3:0]  p1,
    input  logic [3:0]  p2,
    input  logic [3:0]  p3,
    input  logic [3:0]  p4,
    input  logic [3:0]  p5,
    input  logic [3:0]  p6,
    input  logic [3:0]  p7,
    output logic        busy,
    output logic        err,
    output logic [23:0] freq_bin,
    output logic        fout
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CONV  = 2'd1,
        APPLY = 2'd2
    } state_t;

    localparam logic [31:0]      CLK_U   = 32'(CLK_HZ);
    localparam logic [ACC_W-1:0] CLK_ACC = ACC_W'(CLK_HZ);

    // Digit store: index 0 holds p1 (10^6), index 6 holds p7 (10^0).
    state_t           state_q, state_d;
    logic [6:0][3:0]  digits_q, digits_d;
    logic [2:0]       idx_q, idx_d;
    logic [23:0]      bin_q, bin_d;
    logic             busy_q, busy_d;
    logic             err_q, err_d;
    logic [23:0]      freq_q, freq_d;
    logic [ACC_W-1:0] acc_q, acc_d;
    logic             fout_q, fout_d;

    // Conversion and synthesis intermediates.
    logic             digit_bad;
    logic             acc_clr;
    logic [23:0]      bin_x10;
    logic [31:0]      bin_dbl;
    logic [ACC_W-1:0] step;
    logic [ACC_W-1:0] sum;

    // A digit above 9 makes the whole request invalid.
    always_comb begin
        digit_bad = (p1 > 4'd9) || (p2 > 4'd9) || (p3 > 4'd9) || (p4 > 4'd9) ||
                    (p5 > 4'd9) || (p6 > 4'd9) || (p7 > 4'd9);
    end

    // Sequential BCD-to-binary conversion plus range check. 9_999_999 fits in
    // 24 bits, so bin*10 + digit never overflows for valid BCD.
    always_comb begin
        state_d  = state_q;
        digits_d = digits_q;
        idx_d    = idx_q;
        bin_d    = bin_q;
        busy_d   = busy_q;
        err_d    = err_q;
        freq_d   = freq_q;
        acc_clr  = 1'b0;
        bin_x10  = (bin_q << 3) + (bin_q << 1);
        bin_dbl  = {7'd0, bin_q, 1'b0};

        case (state_q)
            IDLE: begin
                if (load) begin
                    if (digit_bad) begin
                        err_d = 1'b1;
                    end else begin
                        digits_d[0] = p1;
                        digits_d[1] = p2;
                        digits_d[2] = p3;
                        digits_d[3] = p4;
                        digits_d[4] = p5;
                        digits_d[5] = p6;
                        digits_d[6] = p7;
                        bin_d       = 24'd0;
                        idx_d       = 3'd0;
                        busy_d      = 1'b1;
                        state_d     = CONV;
                    end
                end
            end
            CONV: begin
                bin_d = bin_x10 + {20'd0, digits_q[idx_q]};
                idx_d = idx_q + 3'd1;
                if (idx_q == 3'd6) begin
                    state_d = APPLY;
                end
            end
            APPLY: begin
                // The square wave needs two toggles per period; at or above
                // CLK_HZ/2 that would mean more than one toggle per clock.
                if (bin_dbl >= CLK_U) begin
                    err_d = 1'b1;
                end else begin
                    freq_d  = bin_q;
                    err_d   = 1'b0;
                    acc_clr = 1'b1;
                end
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    // Phase accumulator. acc stays below CLK_HZ, so acc + 2*freq_bin stays below
    // 2*CLK_HZ and fits ACC_W. A new frequency clears the phase but leaves fout at
    // its current level, so the output never produces a runt pulse.
    always_comb begin
        step   = ACC_W'({freq_q, 1'b0});
        sum    = acc_q + step;
        acc_d  = sum;
        fout_d = fout_q;
        if (sum >= CLK_ACC) begin
            acc_d  = sum - CLK_ACC;
            fout_d = ~fout_q;
        end
        if (acc_clr) begin
            acc_d  = '0;
            fout_d = fout_q;
        end
    end

    // State registers; reset aborts any conversion in progress.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            digits_q <= '0;
            idx_q    <= 3'd0;
            bin_q    <= 24'd0;
            busy_q   <= 1'b0;
            err_q    <= 1'b0;
            freq_q   <= 24'd0;
            acc_q    <= '0;
            fout_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            digits_q <= digits_d;
            idx_q    <= idx_d;
            bin_q    <= bin_d;
            busy_q   <= busy_d;
            err_q    <= err_d;
            freq_q   <= freq_d;
            acc_q    <= acc_d;
            fout_q   <= fout_d;
        end
    end

    assign busy     = busy_q;
    assign err      = err_q;
    assign freq_bin = freq_q;
    assign fout     = fout_q;

endmodule

// File: tb/tb_freq_synth_bcd.sv
// Bench for freq_synth_bcd. A 1 kHz-clock instance covers the directed and random
// scenarios. A default-clock instance covers the full-scale BCD input.
`timescale 1ns/1ps
module tb_freq_synth_bcd;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Small instance, CLK_HZ = 1000.
    logic        rst_n, load;
    logic [3:0]  dg [7];
    logic        busy, err, fout;
    logic [23:0] freq_bin;

    // Default-clock instance.
    logic        rst_big_n, load_big;
    logic [3:0]  bg [7];
    logic        busy_big, err_big, fout_big;
    logic [23:0] freq_big;

    int vectors = 0;
    int miscompares = 0;
    int exp_freq = 0;

    freq_synth_bcd #(.CLK_HZ(1000), .ACC_W(27)) dut (
        .clk(clk), .rst_n(rst_n), .load(load),
        .p1(dg[0]), .p2(dg[1]), .p3(dg[2]), .p4(dg[3]),
        .p5(dg[4]), .p6(dg[5]), .p7(dg[6]),
        .busy(busy), .err(err), .freq_bin(freq_bin), .fout(fout)
    );

    freq_synth_bcd dut_big (
        .clk(clk), .rst_n(rst_big_n), .load(load_big),
        .p1(bg[0]), .p2(bg[1]), .p3(bg[2]), .p4(bg[3]),
        .p5(bg[4]), .p6(bg[5]), .p7(bg[6]),
        .busy(busy_big), .err(err_big), .freq_bin(freq_big), .fout(fout_big)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Decimal digit of f at position pos (0 = 10^6 ... 6 = 10^0).
    function automatic logic [3:0] dig(input int f, input int pos);
        int div = 1;
        for (int i = 0; i < 6 - pos; i++) div = div * 10;
        return 4'((f / div) % 10);
    endfunction

    task automatic set_digits(input int f);
        for (int i = 0; i < 7; i++) dg[i] = dig(f, i);
    endtask

    task automatic pulse_load();
        load = 1'b1;
        tick();
        load = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (busy && n < 20) begin
            tick();
            n++;
        end
        if (busy) begin
            vectors++;
            miscompares++;
            $display("FAIL wait_idle: busy=%0b after %0d cycles, required 0", busy, n);
        end
    endtask

    // Measure fout over n edges: toggles, rising edges, rise-to-rise spacing.
    task automatic measure(input int n, output int tog, output int rises,
                           output int minp, output int maxp);
        logic prev = fout;
        int last = -1;
        tog = 0; rises = 0; minp = 1 << 30; maxp = 0;
        for (int i = 0; i < n; i++) begin
            tick();
            if (fout !== prev) begin
                tog++;
                if (fout === 1'b1) begin
                    rises++;
                    if (last >= 0) begin
                        if (i - last < minp) minp = i - last;
                        if (i - last > maxp) maxp = i - last;
                    end
                    last = i;
                end
            end
            prev = fout;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; rst_big_n = 1'b0; load = 1'b0; load_big = 1'b0;
        set_digits(0);
        for (int i = 0; i < 7; i++) bg[i] = 4'd0;
        tick();
        vectors++;
        if ({busy, err, freq_bin, fout} !== 27'd0) begin
            miscompares++;
            $display("FAIL reset: busy=%0b err=%0b freq=%0d fout=%0b, required all 0",
                     busy, err, freq_bin, fout);
        end
        rst_n = 1'b1; rst_big_n = 1'b1;
        tick();
    endtask

    task automatic test_latency_1hz();
        int n;
        logic f0;
        logic ok = 1'b1;
        set_digits(1);
        pulse_load();
        for (int i = 0; i < 8; i++) begin
            if (busy !== 1'b1) ok = 1'b0;
            if (i < 7) tick();
        end
        vectors++;
        if (!ok) begin
            miscompares++;
            $display("FAIL busy_window: busy dropped during edges k..k+7, required high");
        end
        tick();
        vectors++;
        if (busy !== 1'b0 || freq_bin !== 24'd1) begin
            miscompares++;
            $display("FAIL apply_1hz: busy=%0b freq=%0d, required 0/1", busy, freq_bin);
        end
        exp_freq = 1;
        for (int t = 0; t < 2; t++) begin
            f0 = fout; n = 0;
            while (fout === f0 && n < 2000) begin
                tick();
                n++;
            end
            vectors++;
            if (n !== 500) begin
                miscompares++;
                $display("FAIL half_period_1hz: %0d clks, required 500", n);
            end
        end
    endtask

    task automatic test_period();
        int tog, rises, minp, maxp, n;
        logic f0;
        logic ok = 1'b1;
        set_digits(250);
        pulse_load();
        wait_idle();
        vectors++;
        if (freq_bin !== 24'd250) begin
            miscompares++;
            $display("FAIL freq_250: got %0d, required 250", freq_bin);
        end
        exp_freq = 250;
        f0 = fout;
        n = 0;
        while (fout === f0 && n < 10) begin
            tick();
            n++;
        end
        for (int r = 0; r < 6; r++) begin
            f0 = fout; n = 0;
            while (fout === f0 && n < 10) begin
                tick();
                n++;
            end
            if (n != 2) ok = 1'b0;
        end
        vectors++;
        if (!ok) begin
            miscompares++;
            $display("FAIL run_250: a level lasted %0d clks, required 2", n);
        end
        set_digits(300);
        pulse_load();
        wait_idle();
        exp_freq = 300;
        measure(1000, tog, rises, minp, maxp);
        vectors++;
        if (rises !== 300 || minp < 3 || maxp > 4) begin
            miscompares++;
            $display("FAIL rate_300: rises=%0d period %0d..%0d, required 300 in 3..4",
                     rises, minp, maxp);
        end
    endtask

    task automatic test_out_of_range();
        int tog, rises, minp, maxp;
        set_digits(600);
        pulse_load();
        wait_idle();
        vectors++;
        if (err !== 1'b1 || freq_bin !== 24'd300) begin
            miscompares++;
            $display("FAIL reject_600: err=%0b freq=%0d, required 1/300", err, freq_bin);
        end
        measure(1000, tog, rises, minp, maxp);
        vectors++;
        if (rises !== 300) begin
            miscompares++;
            $display("FAIL rate_kept: rises=%0d, required 300", rises);
        end
        set_digits(100);
        pulse_load();
        wait_idle();
        exp_freq = 100;
        vectors++;
        if (err !== 1'b0 || freq_bin !== 24'd100) begin
            miscompares++;
            $display("FAIL accept_100: err=%0b freq=%0d, required 0/100", err, freq_bin);
        end
    endtask

    task automatic test_bad_digit();
        logic f0;
        logic ok = 1'b1;
        set_digits(0);
        dg[3] = 4'hA;
        pulse_load();
        vectors++;
        if (err !== 1'b1 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL bad_digit: err=%0b busy=%0b, required 1/0", err, busy);
        end
        for (int i = 0; i < 10; i++) begin
            tick();
            if (busy !== 1'b0) ok = 1'b0;
        end
        vectors++;
        if (!ok || freq_bin !== 24'd100) begin
            miscompares++;
            $display("FAIL bad_digit_idle: busy rose or freq=%0d, required 100", freq_bin);
        end
        set_digits(0);
        pulse_load();
        wait_idle();
        exp_freq = 0;
        vectors++;
        if (freq_bin !== 24'd0 || err !== 1'b0) begin
            miscompares++;
            $display("FAIL zero_load: freq=%0d err=%0b, required 0/0", freq_bin, err);
        end
        f0 = fout;
        ok = 1'b1;
        for (int i = 0; i < 300; i++) begin
            tick();
            if (fout !== f0) ok = 1'b0;
        end
        vectors++;
        if (!ok) begin
            miscompares++;
            $display("FAIL zero_freeze: fout=%0b moved, required %0b", fout, f0);
        end
    endtask

    task automatic test_back_to_back();
        int f1 = $urandom_range(1, 499);
        logic ok = 1'b1;
        set_digits(f1);
        pulse_load();
        tick();
        tick();
        set_digits(f1 == 123 ? 77 : 123);
        pulse_load();
        for (int i = 0; i < 5; i++) begin
            if (busy !== 1'b1) ok = 1'b0;
            if (i < 4) tick();
        end
        tick();
        vectors++;
        if (!ok || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL b2b_busy: busy=%0b at k+8 (window ok=%0b), required 0", busy, ok);
        end
        vectors++;
        if (freq_bin !== 24'(f1) || err !== 1'b0) begin
            miscompares++;
            $display("FAIL b2b_result: freq=%0d err=%0b, required %0d/0", freq_bin, err, f1);
        end
        exp_freq = f1;
    endtask

    task automatic test_random();
        int f, n, tog, rises, minp, maxp;
        longint exp_tog;
        bit accept;
        for (int it = 0; it < 8; it++) begin
            if ($urandom_range(0, 9) < 2) f = $urandom_range(500, 9999999);
            else f = $urandom_range(0, 499);
            accept = (2 * f < 1000);
            set_digits(f);
            pulse_load();
            wait_idle();
            if (accept) exp_freq = f;
            vectors++;
            if (freq_bin !== 24'(exp_freq) || err !== !accept) begin
                miscompares++;
                $display("FAIL rand_load f=%0d: freq=%0d err=%0b, required %0d/%0b",
                         f, freq_bin, err, exp_freq, !accept);
            end
            if (accept) begin
                n = $urandom_range(100, 1500);
                measure(n, tog, rises, minp, maxp);
                exp_tog = (longint'(n) * 2 * f) / 1000;
                vectors++;
                if (longint'(tog) != exp_tog) begin
                    miscompares++;
                    $display("FAIL rand_toggles f=%0d n=%0d: %0d, required %0d",
                             f, n, tog, exp_tog);
                end
            end
        end
    endtask

    task automatic test_full_scale();
        int n = 0;
        int tog = 0;
        logic prev;
        longint exp_tog;
        for (int i = 0; i < 7; i++) bg[i] = 4'd9;
        load_big = 1'b1;
        tick();
        load_big = 1'b0;
        while (busy_big && n < 20) begin
            tick();
            n++;
        end
        vectors++;
        if (busy_big !== 1'b0 || freq_big !== 24'd9_999_999 || err_big !== 1'b0) begin
            miscompares++;
            $display("FAIL full_scale: busy=%0b freq=%0d err=%0b, required 0/9999999/0",
                     busy_big, freq_big, err_big);
        end
        prev = fout_big;
        for (int i = 0; i < 50000; i++) begin
            tick();
            if (fout_big !== prev) tog++;
            prev = fout_big;
        end
        exp_tog = (longint'(50000) * 2 * 9_999_999) / 50_000_000;
        vectors++;
        if (longint'(tog) != exp_tog) begin
            miscompares++;
            $display("FAIL full_scale_toggles: %0d, required %0d", tog, exp_tog);
        end
    endtask

    task automatic test_reset_mid_conv();
        int n = 0;
        set_digits(123);
        pulse_load();
        wait_idle();
        while (fout !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        set_digits(456);
        pulse_load();
        tick();
        tick();
        rst_n = 1'b0;
        #1;
        vectors++;
        if (busy !== 1'b0 || freq_bin !== 24'd0 || fout !== 1'b0 || err !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_mid_conv: busy=%0b freq=%0d fout=%0b err=%0b, required 0",
                     busy, freq_bin, fout, err);
        end
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    initial begin
        test_reset();
        test_latency_1hz();
        test_period();
        test_out_of_range();
        test_bad_digit();
        test_back_to_back();
        test_random();
        test_full_scale();
        test_reset_mid_conv();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
